led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator for the board status LEDs. It replaces the fixed 4-LED, counter-MSB walker.
- Supports N LEDs, a programmable step period, four selectable patterns and PWM breathing, plus pause, a step strobe and a heartbeat output.
- Sits directly between top-level mode/pause inputs (straps or a debug register) and the LED pins. Registered outputs only.

Parameters:
- NLEDS, 4, number of pattern LEDs; legal range 2..32.
- DIV, 3000000, clk cycles per pattern step. Legal range 2..2^32-1. 3000000 gives 4 steps/s at 12 MHz.
- PWM_BITS, 8, breathe-mode brightness and PWM counter width; legal range 2..12.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  2  pattern select: 0 rotate, 1 bounce, 2 binary count, 3 breathe.
- pause  in  1  when high, the pattern freezes.
- led  out  NLEDS  pattern output, registered.
- step  out  1  one-cycle strobe, high in the cycle a new step value appears on led.
- hb  out  1  heartbeat; toggles on every step.

Behaviour:
- Reset, while rst=1:
  - led=0, step=0, hb=0.
  - Prescaler pre=0, pos=0, dir=up, cnt=0, level=0, PWM counter=0, mode_q=mode.
- First cycle after rst falls: led shows the step-0 pattern for the current mode.
  - Rotate/bounce: led=1.
  - Binary: led=0.
  - Breathe: led=0 (level 0).
- Prescaler:
  - pre counts 0..DIV-1 and wraps to 0.
  - The tick event is pre==DIV-1 && !pause && no mode change that cycle.
  - On tick, the pattern state advances. led, step=1 and the hb toggle become visible on the next edge, with the same latency for all three.
  - With continuous run, the step period is exactly DIV cycles.
- Pause:
  - pre, pos, dir, cnt, level, led and hb hold; step=0.
  - The PWM counter keeps running, so breathe output keeps modulating at the held level.
  - On pause release, the count resumes from the held pre value; no extra tick.
- Mode change (mode != mode_q, registered each cycle):
  - Clears pre, pos, cnt and level, and sets dir=up; no tick that cycle.
  - led shows the new mode's step-0 pattern on the next edge; step stays 0.
  - A change during pause is still applied.
- Rotate: led = 1<<pos; pos increments and wraps NLEDS-1 -> 0.
- Bounce:
  - led = 1<<pos. Endpoints are shown once per sweep.
  - dir up: pos+1; at pos==NLEDS-1, set dir=down and pos=NLEDS-2.
  - dir down: mirror rule at pos 0.
  - NLEDS=2 gives 0,1,0,1.
- Binary: led = cnt; cnt is NLEDS bits, +1 per tick, wraps all-ones -> 0.
- Breathe:
  - level rises 0..2^PWM_BITS-1, then falls to 0, then rises; endpoints are held one step each.
  - The free-running PWM counter pwm (PWM_BITS wide) increments every clk and wraps.
  - All LEDs = (pwm < level), registered.
  - level 0 gives constant off; max level gives duty (2^PWM_BITS-1)/2^PWM_BITS.
- hb toggles on each tick regardless of mode. It does not toggle on mode change or pause.
- Simultaneous events:
  - rst overrides everything.
  - Mode change overrides tick.
  - Pause suppresses tick.
- Widths: pre is ceil(log2(DIV)) bits; pos is ceil(log2(NLEDS)) bits. There is no overflow path besides the defined wraps.

Test Plan:
- Reset, then rotate. NLEDS=4, DIV=4, mode=0: led=0 during rst, then 0001. Steps every 4 cycles give 0010, 0100, 1000, 0001. step is high 1 cycle per change; hb toggles each step.
- Bounce. mode=1, NLEDS=4: led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. No endpoint repeats.
- Binary wrap. mode=2, NLEDS=3: led 000, 001, ..., 111, 000. step count = 8 over 32 cycles with DIV=4.
- Breathe PWM. mode=3, PWM_BITS=4: at level 5, led=1111 for exactly 5 of each 16 cycles. level sequence 0..15, 14..0, 1. At level 0, led is never high.
- Pause mid-step. Assert pause at pre=2 for 10 cycles: led, hb and step are frozen. After release, the next step arrives exactly 2 cycles later (pre 2 -> 3 -> tick).
- Mode change on a tick cycle. Switch 0 -> 1 when pre=DIV-1 and pos=2: no step pulse. Next led=0001, and the following step occurs DIV cycles later. Reset asserted mid-bounce returns led=0, hb=0.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Parametrised status-LED pattern generator: rotate, bounce, binary count and
// PWM breathing, stepped by a prescaler, with pause, step strobe and heartbeat.
module led_pattern_gen #(
  parameter int          NLEDS    = 4,
  parameter int unsigned DIV      = 3000000,
  parameter int          PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [NLEDS-1:0] led,
  output logic             step,
  output logic             hb
);

  localparam int PREW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POSW = $clog2(NLEDS);
  localparam logic [PREW-1:0]     PRE_LAST = PREW'(DIV - 1);
  localparam logic [POSW-1:0]     POS_LAST = POSW'(NLEDS - 1);
  localparam logic [POSW-1:0]     POS_PEN  = POSW'(NLEDS - 2);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_PEN  = LVL_MAX - PWM_BITS'(1);

  typedef enum logic [1:0] {
    M_ROTATE  = 2'd0,
    M_BOUNCE  = 2'd1,
    M_BINARY  = 2'd2,
    M_BREATHE = 2'd3
  } mode_t;

  logic [PREW-1:0]     pre, pre_nx;
  logic [POSW-1:0]     pos, pos_nx;
  logic                dir, dir_nx;   // 1 = moving down (bounce position or breathe level)
  logic [NLEDS-1:0]    cnt, cnt_nx;
  logic [PWM_BITS-1:0] level, level_nx;
  logic [PWM_BITS-1:0] pwm;
  logic [1:0]          mode_q;
  logic [NLEDS-1:0]    led_nx;
  logic                mode_chg;
  logic                tick;

  assign mode_chg = (mode != mode_q);
  assign tick     = (pre == PRE_LAST) && !pause && !mode_chg;

  // Next pattern state: mode change clears, tick advances, otherwise prescale or hold.
  always_comb begin
    pre_nx   = pre;
    pos_nx   = pos;
    dir_nx   = dir;
    cnt_nx   = cnt;
    level_nx = level;
    if (mode_chg) begin
      pre_nx   = '0;
      pos_nx   = '0;
      dir_nx   = 1'b0;
      cnt_nx   = '0;
      level_nx = '0;
    end else if (tick) begin
      pre_nx = '0;
      case (mode_t'(mode))
        M_ROTATE: begin
          pos_nx = (pos == POS_LAST) ? '0 : pos + POSW'(1);
        end
        M_BOUNCE: begin
          // Endpoints are shown once: turn around by jumping to the neighbour.
          if (!dir) begin
            if (pos == POS_LAST) begin
              dir_nx = 1'b1;
              pos_nx = POS_PEN;
            end else begin
              pos_nx = pos + POSW'(1);
            end
          end else begin
            if (pos == '0) begin
              dir_nx = 1'b0;
              pos_nx = POSW'(1);
            end else begin
              pos_nx = pos - POSW'(1);
            end
          end
        end
        M_BINARY: begin
          cnt_nx = cnt + NLEDS'(1);
        end
        M_BREATHE: begin
          if (!dir) begin
            if (level == LVL_MAX) begin
              dir_nx   = 1'b1;
              level_nx = LVL_PEN;
            end else begin
              level_nx = level + PWM_BITS'(1);
            end
          end else begin
            if (level == '0) begin
              dir_nx   = 1'b0;
              level_nx = PWM_BITS'(1);
            end else begin
              level_nx = level - PWM_BITS'(1);
            end
          end
        end
        default: begin
          pos_nx = pos;
        end
      endcase
    end else if (!pause) begin
      pre_nx = pre + PREW'(1);
    end else begin
      pre_nx = pre;
    end
  end

  // LED image of the next state, so led, step and hb all change on the same edge.
  always_comb begin
    led_nx = '0;
    case (mode_t'(mode))
      M_ROTATE:  led_nx = NLEDS'(1) << pos_nx;
      M_BOUNCE:  led_nx = NLEDS'(1) << pos_nx;
      M_BINARY:  led_nx = cnt_nx;
      M_BREATHE: led_nx = (pwm < level_nx) ? {NLEDS{1'b1}} : {NLEDS{1'b0}};
      default:   led_nx = '0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      pos    <= '0;
      dir    <= 1'b0;
      cnt    <= '0;
      level  <= '0;
      pwm    <= '0;
      mode_q <= mode;
      led    <= '0;
      step   <= 1'b0;
      hb     <= 1'b0;
    end else begin
      pre    <= pre_nx;
      pos    <= pos_nx;
      dir    <= dir_nx;
      cnt    <= cnt_nx;
      level  <= level_nx;
      pwm    <= pwm + PWM_BITS'(1);
      mode_q <= mode;
      led    <= led_nx;
      step   <= tick;
      hb     <= hb ^ tick;
    end
  end

endmodule
